// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO on a shift-register array; new data enters at
// r[0], and the occupancy counter addresses the oldest entry at r[count-1].
module srl_fifo #(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 16,
  parameter int AFULL_LEVEL     = DEPTH - 2,
  parameter bit IS_CLK_INVERTED = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           D,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [WIDTH-1:0]           Q,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       ALMOST_FULL
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [WIDTH-1:0] r [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    head_full;
  logic [AW-1:0]    head;
  logic             active_clk;
  logic             push;
  logic             pop;

  // Inverting the clock moves every state update onto the falling edge.
  assign active_clk = CLK ^ IS_CLK_INVERTED;

  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;
  assign head_full = count - CW'(1);
  assign head      = head_full[AW-1:0];
  assign COUNT     = count;

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge active_clk) begin
    if (RST) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Shift storage; never reset, since the counter alone defines valid entries.
  always_ff @(posedge active_clk) begin
    if (push) begin
      r[0] <= D;
      for (int i = 1; i < DEPTH; i++) begin
        r[i] <= r[i-1];
      end
    end
  end

  // Status and head data, all gated off while reset is asserted.
  always_comb begin
    IN_READY    = 1'b0;
    OUT_VALID   = 1'b0;
    ALMOST_FULL = 1'b0;
    Q           = '0;
    if (RST) begin
      IN_READY    = 1'b0;
      OUT_VALID   = 1'b0;
      ALMOST_FULL = 1'b0;
      Q           = '0;
    end else begin
      IN_READY    = (count < DEPTH_C);
      OUT_VALID   = (count != CW'(0));
      ALMOST_FULL = (count >= AFULL_C);
      if (count != CW'(0)) begin
        Q = r[head];
      end else begin
        Q = '0;
      end
    end
  end

endmodule

// File: tb/tb_srl_fifo.sv
// Directed vector table for an 8x16 FIFO, plus a randomized queue-model sweep
// over small, wide, deep and falling-edge configurations.
module tb_srl_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main 8x16 instance
  logic       rst, iv, ordy, ir, ov, af;
  logic [7:0] d, q;
  logic [4:0] cnt;

  srl_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .CLK(clk), .RST(rst), .D(d), .IN_VALID(iv), .IN_READY(ir), .Q(q),
    .OUT_VALID(ov), .OUT_READY(ordy), .COUNT(cnt), .ALMOST_FULL(af)
  );

  // Sweep instances share stimulus
  logic        srst, sv, sr;
  logic [63:0] sd;
  logic        ira, ova, afa, irb, ovb, afb, irc, ovc, afc;
  logic [0:0]  qa;
  logic [63:0] qb;
  logic [7:0]  qc;
  logic [2:0]  cnta;
  logic [1:0]  cntb;
  logic [8:0]  cntc;

  srl_fifo #(.WIDTH(1), .DEPTH(5), .AFULL_LEVEL(3), .IS_CLK_INVERTED(1'b1)) ua (
    .CLK(clk), .RST(srst), .D(sd[0:0]), .IN_VALID(sv), .IN_READY(ira), .Q(qa),
    .OUT_VALID(ova), .OUT_READY(sr), .COUNT(cnta), .ALMOST_FULL(afa)
  );
  srl_fifo #(.WIDTH(64), .DEPTH(2), .AFULL_LEVEL(1)) ub (
    .CLK(clk), .RST(srst), .D(sd), .IN_VALID(sv), .IN_READY(irb), .Q(qb),
    .OUT_VALID(ovb), .OUT_READY(sr), .COUNT(cntb), .ALMOST_FULL(afb)
  );
  srl_fifo #(.WIDTH(8), .DEPTH(256)) uc (
    .CLK(clk), .RST(srst), .D(sd[7:0]), .IN_VALID(sv), .IN_READY(irc), .Q(qc),
    .OUT_VALID(ovc), .OUT_READY(sr), .COUNT(cntc), .ALMOST_FULL(afc)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic [4:0] cnt;
    logic       ir;
    logic       ov;
    logic [7:0] q;
    logic       af;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic r_, input logic iv_, input int d_, input logic or_,
                              input int c_, input logic ir_, input logic ov_, input int q_,
                              input logic af_);
    vec_t v;
    v.rst = r_; v.iv = iv_; v.d = 8'(d_); v.ordy = or_;
    v.cnt = 5'(c_); v.ir = ir_; v.ov = ov_; v.q = 8'(q_); v.af = af_;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; iv = v.iv; d = v.d; ordy = v.ordy;
    @(posedge clk); #1;
    vectors++;
    if (cnt !== v.cnt || ir !== v.ir || ov !== v.ov || q !== v.q || af !== v.af) begin
      miscompares++;
      $display("FAIL vec%0d: got cnt=%0d in_ready=%b out_valid=%b q=%h afull=%b, want cnt=%0d in_ready=%b out_valid=%b q=%h afull=%b",
               idx, cnt, ir, ov, q, af, v.cnt, v.ir, v.ov, v.q, v.af);
    end
  endtask

  task automatic chk_sweep(input string nm, input int c, input logic ir_, input logic ov_,
                           input logic af_, input logic [63:0] q_, input int depth,
                           input int afl, input int mcount, input logic [63:0] mfront);
    logic [63:0] eq;
    eq = (mcount > 0) ? mfront : 64'd0;
    vectors++;
    if (c != mcount || c > depth || ir_ !== (mcount < depth) || ov_ !== (mcount > 0) ||
        af_ !== (mcount >= afl) || q_ !== eq) begin
      miscompares++;
      $display("FAIL sweep %s: got cnt=%0d in_ready=%b out_valid=%b afull=%b q=%h, want cnt=%0d q=%h",
               nm, c, ir_, ov_, af_, q_, mcount, eq);
    end
  endtask

  logic [63:0] ma[$], mb[$], mc[$];

  initial begin
    int   pv, c;
    logic pa, pb, pc, qpa, qpb, qpc;

    rst = 1'b1; iv = 1'b0; d = 8'h00; ordy = 1'b0;
    srst = 1'b1; sv = 1'b0; sr = 1'b0; sd = 64'd0;

    // Reset held with the producer already offering data
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1'b1, 1'b1, 8'hEE, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1'b0, 1'b1, k, 1'b0, k, k < 16, 1'b1, 8'h01, k >= 14));
    vecs.push_back(mk(1'b0, 1'b1, 8'h11, 1'b0, 16, 1'b0, 1'b1, 8'h01, 1'b1));
    for (int j = 1; j <= 16; j++) begin
      c = 16 - j;
      vecs.push_back(mk(1'b0, 1'b0, 0, 1'b1, c, 1'b1, c > 0, (c > 0) ? j + 1 : 0, c >= 14));
    end
    vecs.push_back(mk(1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b1, 1'b1, 8'hA5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1'b0, 1'b1, 8'h20 + k, 1'b0, k + 1, 1'b1, 1'b1, 8'h20, 1'b0));
    for (int m = 1; m <= 20; m++) vecs.push_back(mk(1'b0, 1'b1, 8'h24 + m, 1'b1, 5, 1'b1, 1'b1, 8'h20 + m, 1'b0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1'b0, 1'b1, 8'h40 + k, 1'b0, 6 + k, 1'b1, 1'b1, 8'h34, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b0, 1, 1'b1, 1'b1, 8'h3C, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0));
    for (int k = 0; k < 16; k++) vecs.push_back(mk(1'b0, 1'b1, 8'h50 + k, 1'b0, k + 1, k < 15, 1'b1, 8'h50, k + 1 >= 14));
    // Full with both sides active: only the pop happens
    vecs.push_back(mk(1'b0, 1'b1, 8'h99, 1'b1, 15, 1'b1, 1'b1, 8'h51, 1'b1));
    for (int j = 1; j <= 15; j++) begin
      c = 15 - j;
      vecs.push_back(mk(1'b0, 1'b0, 0, 1'b1, c, 1'b1, c > 0, (c > 0) ? 8'h51 + j : 0, c >= 14));
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    iv = 1'b0; ordy = 1'b0;

    // Random sweep: release reset just after a rising edge
    @(posedge clk); @(posedge clk); #1;
    srst = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      pv = ((cyc / 1000) % 2 == 0) ? 80 : 30;
      sv = ($urandom_range(99) < pv);
      sr = ($urandom_range(99) < (110 - pv));
      sd = {$urandom, $urandom};
      pa = sv && (ma.size() < 5);   qpa = sr && (ma.size() > 0);
      pb = sv && (mb.size() < 2);   qpb = sr && (mb.size() > 0);
      pc = sv && (mc.size() < 256); qpc = sr && (mc.size() > 0);

      @(negedge clk); #1;
      if (qpa) void'(ma.pop_front());
      if (pa) ma.push_back({63'd0, sd[0]});
      chk_sweep("d5w1inv", int'(cnta), ira, ova, afa, {63'd0, qa}, 5, 3, ma.size(),
                (ma.size() > 0) ? ma[0] : 64'd0);

      @(posedge clk); #1;
      if (qpb) void'(mb.pop_front());
      if (pb) mb.push_back(sd);
      if (qpc) void'(mc.pop_front());
      if (pc) mc.push_back({56'd0, sd[7:0]});
      chk_sweep("d2w64", int'(cntb), irb, ovb, afb, qb, 2, 1, mb.size(),
                (mb.size() > 0) ? mb[0] : 64'd0);
      chk_sweep("d256w8", int'(cntc), irc, ovc, afc, {56'd0, qc}, 256, 254, mc.size(),
                (mc.size() > 0) ? mc[0] : 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
